// File: rtl/mod_counter_pkg.sv
// Shared defaults, direction/mode encodings and the load clamp helper for mod_counter.
package mod_counter_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_MAX_VAL  = (1 << DEF_WIDTH) - 1;
  localparam int unsigned DEF_PRESCALE = 4;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Evaluated at 32 bits so it serves every legal WIDTH; callers truncate back.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/mod_counter_prescale.sv
// Step divider for mod_counter: counts enabled cycles 0..PRESCALE-1 and ticks on the last one.
module mod_counter_prescale #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick_o  = en_i & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (en_i)   cnt_d = at_last ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with clamped load, wrap/saturate mode, tc, wrap pulse and sticky ovf.
// Optional step prescaler is compiled in when COUNTER_PRESCALE_EN is defined.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 2..32");
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("mod_counter: MAX_VAL must be at least 1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] load_clamped;
  logic             step;

`ifdef COUNTER_PRESCALE_EN
  mod_counter_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (en),
    .clr_i   (load),
    .tick_o  (step)
  );
`else
  assign step = en;
`endif

  assign terminal     = (dir == DIR_UP) ? MAX_VAL : '0;
  assign tc           = (count_q == terminal);
  assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;
    if (load) begin
      count_d = load_clamped;
    end else if (step) begin
      if (!tc) begin
        count_d = (dir == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end else begin
        // Terminal step: flags set in both modes, set beats a same-cycle clr_ovf.
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
        if (sat != MODE_SAT) count_d = (dir == DIR_UP) ? '0 : MAX_VAL;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter (WIDTH=4, MAX_VAL=9): vector table plus reset and prescaler sequences.
module tb_mod_counter;

  localparam int unsigned W  = 4;
  localparam logic [W-1:0] MV = 4'd9;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en, load, dir, sat, clr_ovf;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, wrap, ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_counter #(
    .WIDTH    (W),
    .MAX_VAL  (MV),
    .PRESCALE (1)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .sat      (sat),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .ovf      (ovf)
  );

`ifdef COUNTER_PRESCALE_EN
  logic [W-1:0] count_ps;
  logic         tc_ps, wrap_ps, ovf_ps;

  mod_counter #(
    .WIDTH    (W),
    .MAX_VAL  (MV),
    .PRESCALE (4)
  ) u_dut_ps (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .sat      (sat),
    .clr_ovf  (clr_ovf),
    .count    (count_ps),
    .tc       (tc_ps),
    .wrap     (wrap_ps),
    .ovf      (ovf_ps)
  );
`endif

  typedef struct {
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         dir;
    logic         sat;
    logic         clr_ovf;
    logic [W-1:0] exp_count;
    logic         exp_tc;
    logic         exp_wrap;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [W-1:0] lv, input logic e,
                              input logic d, input logic s, input logic c,
                              input logic [W-1:0] ec, input logic et, input logic ew,
                              input logic eo);
    vec_t v;
    v.load = ld; v.load_val = lv; v.en = e; v.dir = d; v.sat = s; v.clr_ovf = c;
    v.exp_count = ec; v.exp_tc = et; v.exp_wrap = ew; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic e,
                       input logic d, input logic s, input logic c);
    load = ld; load_val = lv; en = e; dir = d; sat = s; clr_ovf = c;
  endtask

  initial begin
    // Wrap up from 0 through 9 back to 0.
    for (int i = 1; i <= 9; i++)
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, W'(i), (i == 9), 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0, 0, 1));
    // Load beats step, and 15 clamps to MAX_VAL.
    vecs.push_back(mk(1, 15, 1, 1, 0, 0, 9, 1, 0, 1));
    // Set and clear of ovf together: set wins; then a plain clear.
    vecs.push_back(mk(0, 0,  1, 1, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0,  0, 1, 0, 1, 0, 0, 0, 0));
    // Saturate down from 2.
    vecs.push_back(mk(1, 2,  0, 0, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 0, 1, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0,  1, 0, 1, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0,  1, 0, 1, 0, 0, 1, 1, 1));
    // Wrap down 0 -> 9, then a normal step.
    vecs.push_back(mk(0, 0,  1, 0, 0, 0, 9, 0, 1, 1));
    vecs.push_back(mk(0, 0,  1, 0, 0, 0, 8, 0, 0, 1));
    // Flip to up/saturate mid-count, saturate at 9, then hold.
    vecs.push_back(mk(0, 0,  1, 1, 1, 0, 9, 1, 0, 1));
    vecs.push_back(mk(0, 0,  1, 1, 1, 0, 9, 1, 1, 1));
    vecs.push_back(mk(0, 0,  0, 1, 1, 0, 9, 1, 0, 1));
    // In-range loads, one with a concurrent ovf clear.
    vecs.push_back(mk(1, 5,  1, 0, 0, 1, 5, 0, 0, 0));
    vecs.push_back(mk(1, 9,  0, 1, 0, 0, 9, 1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 6,  0, 1, 0, 0, 6, 0, 0, 1));

    // Reset state, asserted before any clock edge.
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("reset_count", 32'(count), 0);
    check("reset_wrap",  32'(wrap),  0);
    check("reset_ovf",   32'(ovf),   0);
    check("reset_tc_down", 32'(tc), 1);
    dir = 1'b1;
    #1;
    check("reset_tc_up", 32'(tc), 0);
    dir = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].dir, vecs[i].sat, vecs[i].clr_ovf);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_tc", i),    32'(tc),    32'(vecs[i].exp_tc));
      check($sformatf("vec%0d_wrap", i),  32'(wrap),  32'(vecs[i].exp_wrap));
      check($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(vecs[i].exp_ovf));
    end

    // Mid-count reset at count=6 with ovf set: clears between edges.
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_count", 32'(count), 0);
    check("midreset_ovf",   32'(ovf),   0);
    check("midreset_wrap",  32'(wrap),  0);

    // Build a pending wrap pulse (saturate at 9), then reset between edges.
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 9, 0, 1, 1, 0);
    @(negedge clk);
    drive(0, 0, 1, 1, 1, 0);
    @(posedge clk);
    #1;
    check("pre_reset_wrap", 32'(wrap), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("wrapreset_count", 32'(count), 0);
    check("wrapreset_wrap",  32'(wrap),  0);
    check("wrapreset_ovf",   32'(ovf),   0);

    // Held reset ignores en across an edge; release steps on the next edge.
    drive(0, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    check("held_reset_count", 32'(count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_count", 32'(count), 1);

`ifdef COUNTER_PRESCALE_EN
    // PRESCALE=4: one step per four enabled cycles; a load restarts the period.
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("ps_run%0d", k), 32'(count_ps), 32'(k / 4));
    end
    @(negedge clk);
    drive(1, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    check("ps_load", 32'(count_ps), 0);
    @(negedge clk);
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("ps_after_load%0d", k), 32'(count_ps), 32'(k / 4));
    end
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
